// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Holds the FSM encoding, segment bit order, glyph constants and clog2.
// Leading-zero blanking is enabled in the top by defining SEG7_LZB_EN.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Segment bit positions inside a glyph word {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_A_M = 7'(1) << SEG_A;
  localparam logic [6:0] SEG_B_M = 7'(1) << SEG_B;
  localparam logic [6:0] SEG_C_M = 7'(1) << SEG_C;
  localparam logic [6:0] SEG_D_M = 7'(1) << SEG_D;
  localparam logic [6:0] SEG_E_M = 7'(1) << SEG_E;
  localparam logic [6:0] SEG_F_M = 7'(1) << SEG_F;
  localparam logic [6:0] SEG_G_M = 7'(1) << SEG_G;

  localparam logic [6:0] GLYPH_0 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M;
  localparam logic [6:0] GLYPH_1 = SEG_B_M | SEG_C_M;
  localparam logic [6:0] GLYPH_2 = SEG_A_M | SEG_B_M | SEG_D_M | SEG_E_M | SEG_G_M;
  localparam logic [6:0] GLYPH_3 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_G_M;
  localparam logic [6:0] GLYPH_4 = SEG_B_M | SEG_C_M | SEG_F_M | SEG_G_M;
  localparam logic [6:0] GLYPH_5 = SEG_A_M | SEG_C_M | SEG_D_M | SEG_F_M | SEG_G_M;
  localparam logic [6:0] GLYPH_6 = SEG_A_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M | SEG_G_M;
  localparam logic [6:0] GLYPH_7 = SEG_A_M | SEG_B_M | SEG_C_M;
  localparam logic [6:0] GLYPH_8 = GLYPH_0 | SEG_G_M;
  localparam logic [6:0] GLYPH_9 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_F_M | SEG_G_M;
  localparam logic [6:0] GLYPH_DASH  = SEG_G_M;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Ceiling log2; returns 0 for v <= 1 so callers clamp to a minimum width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to seven-segment glyph decoder.
// Non-BCD codes (10..15) render as a dash so bad data is visible.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_glyph
);

  // Glyph lookup
  always_comb begin
    o_glyph = GLYPH_DASH;
    case (i_nib)
      4'd0:    o_glyph = GLYPH_0;
      4'd1:    o_glyph = GLYPH_1;
      4'd2:    o_glyph = GLYPH_2;
      4'd3:    o_glyph = GLYPH_3;
      4'd4:    o_glyph = GLYPH_4;
      4'd5:    o_glyph = GLYPH_5;
      4'd6:    o_glyph = GLYPH_6;
      4'd7:    o_glyph = GLYPH_7;
      4'd8:    o_glyph = GLYPH_8;
      4'd9:    o_glyph = GLYPH_9;
      default: o_glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with per-digit dwell and blanking
// dead-time. Input data is captured once per frame into a shadow copy.
// Optional leading-zero blanking: define SEG7_LZB_EN.
// All outputs are registered from next-state values so selects and
// segments always switch together.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 10,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIGITS*4-1:0]   i_bcd_data,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_frame_start
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int IDX_W   = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic                     latch;

  logic [DIGITS-1:0][3:0]   bcd_in;
  logic [DIGITS-1:0][3:0]   shadow, shadow_nxt;
  logic [DIGITS-1:0]        shadow_dp, shadow_dp_nxt;

  logic [3:0]               nib_sel;
  logic [6:0]               glyph;
  logic                     digit_blank;

  logic [6:0]               seg_nxt;
  logic                     dp_nxt;
  logic [DIGITS-1:0]        sel_nxt;

  assign bcd_in = i_bcd_data;

  // Next-state and dwell counting; a frame latch happens on every SHOW
  // entry whose digit index wraps back to 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    latch     = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_SHOW;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          latch     = (idx == IDX_LAST);
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_BLANK;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_BLANK;
      end
    endcase
  end

  // Shadow data follows the inputs only on a frame latch; digit 0 of the
  // new frame is decoded straight from the values captured on that edge.
  always_comb begin
    shadow_nxt    = latch ? bcd_in : shadow;
    shadow_dp_nxt = latch ? i_dp   : shadow_dp;
    nib_sel       = shadow_nxt[idx_nxt];
  end

  seg7_decoder u_dec (
    .i_nib   (nib_sel),
    .o_glyph (glyph)
  );

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lzb_mask, lzb_mask_nxt;

  // Leading-zero run from the top digit down; digit 0 always shows and a
  // set decimal point ends the run.
  always_comb begin
    logic run;
    logic [DIGITS-1:0] m;
    run          = 1'b1;
    m            = '0;
    lzb_mask_nxt = lzb_mask;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (run && (bcd_in[d] == 4'd0) && !i_dp[d]) m[d] = 1'b1;
      else                                        run  = 1'b0;
    end
    if (latch) lzb_mask_nxt = m;
  end

  // Mask register, refreshed at each frame latch
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) lzb_mask <= '0;
    else        lzb_mask <= lzb_mask_nxt;
  end

  assign digit_blank = lzb_mask_nxt[idx_nxt];
`else
  assign digit_blank = 1'b0;
`endif

  // Output values for the cycle after this edge
  always_comb begin
    seg_nxt = GLYPH_BLANK;
    dp_nxt  = 1'b0;
    sel_nxt = '0;
    if (state_nxt == ST_SHOW) begin
      sel_nxt = DIGITS'(1) << idx_nxt;
      seg_nxt = digit_blank ? GLYPH_BLANK : glyph;
      dp_nxt  = shadow_dp_nxt[idx_nxt];
    end
  end

  // State, counters, shadow and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= IDX_LAST;
      shadow        <= '0;
      shadow_dp     <= '0;
      o_seg         <= '0;
      o_dp          <= 1'b0;
      o_digit_sel   <= '0;
      o_frame_start <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      shadow        <= shadow_nxt;
      shadow_dp     <= shadow_dp_nxt;
      o_seg         <= seg_nxt;
      o_dp          <= dp_nxt;
      o_digit_sel   <= sel_nxt;
      o_frame_start <= latch;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
// The reference model derives every output from the number of clock edges
// since reset release plus a per-frame snapshot of the inputs.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int S = 4;
  localparam int B = 1;
  localparam int P = D * (S + B);

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  bcd;
  logic [3:0]   dp;
  logic [6:0]   o_seg;
  logic         o_dp;
  logic [3:0]   o_digit_sel;
  logic         o_frame_start;

  int checks = 0;
  int errors = 0;

  // model state
  int         k = 0;
  logic [3:0] sh [4];
  logic [3:0] sdp = '0;
  logic [3:0] mmask = '0;
  int         cur_digit, cur_w;
  logic [3:0] exp_sel;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fs;

  logic [6:0] gl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                          7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                          7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_bcd_data    (bcd),
    .i_dp          (dp),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_digit_sel   (o_digit_sel),
    .o_frame_start (o_frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 32'(o_digit_sel), 32'd0);
    chk({tag, "_seg"}, 32'(o_seg), 32'd0);
    chk({tag, "_dp"},  32'(o_dp), 32'd0);
    chk({tag, "_fs"},  32'(o_frame_start), 32'd0);
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic step();
    int p, dg, w;
    bit run;
    @(posedge clk);
    if (!rst) begin
      k = 0;
      for (int d = 0; d < D; d++) sh[d] = 4'd0;
      sdp = '0;
      mmask = '0;
    end else begin
      k++;
      if (k >= B && ((k - B) % P) == 0) begin
        for (int d = 0; d < D; d++) sh[d] = bcd[4*d +: 4];
        sdp = dp;
        mmask = '0;
`ifdef SEG7_LZB_EN
        run = 1'b1;
        for (int d = D - 1; d >= 1; d--) begin
          if (run && sh[d] == 4'd0 && !sdp[d]) mmask[d] = 1'b1;
          else run = 1'b0;
        end
`endif
      end
    end
    @(negedge clk);
    exp_sel = '0; exp_seg = '0; exp_dp = 1'b0; exp_fs = 1'b0;
    cur_digit = -1; cur_w = -1;
    if (k >= B) begin
      p  = (k - B) % P;
      dg = p / (S + B);
      w  = p % (S + B);
      if (w < S) begin
        cur_digit = dg; cur_w = w;
        exp_sel = 4'(1) << dg;
        exp_seg = mmask[dg] ? 7'd0 : gl[sh[dg]];
        exp_dp  = sdp[dg];
        exp_fs  = (p == 0);
      end
    end
    chk("model_sel", 32'(o_digit_sel), 32'(exp_sel));
    chk("model_seg", 32'(o_seg), 32'(exp_seg));
    chk("model_dp",  32'(o_dp), 32'(exp_dp));
    chk("model_fs",  32'(o_frame_start), 32'(exp_fs));
  endtask

  // Step until digit d starts its SHOW window; bounded.
  task automatic wait_digit(input int d);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 2 * P && !found; n++) begin
      step();
      if (cur_digit == d && cur_w == 0) found = 1'b1;
    end
    if (!found) chk("wait_digit_timeout", 32'd0, 32'd1);
  endtask

  // Release reset at a falling edge and check the restart sequence.
  task automatic release_and_check(input string tag);
    rst = 1'b1;
    for (int n = 1; n <= P + 1; n++) begin
      step();
      if (n == 1) begin
        chk({tag, "_first_sel"}, 32'(o_digit_sel), 32'h1);
        chk({tag, "_first_fs"},  32'(o_frame_start), 32'h1);
      end
      if (n == 4) chk({tag, "_hold_sel"},  32'(o_digit_sel), 32'h1);
      if (n == 5) chk({tag, "_blank_sel"}, 32'(o_digit_sel), 32'h0);
      if (n == 6) chk({tag, "_next_sel"},  32'(o_digit_sel), 32'h2);
      if (n == P + 1) chk({tag, "_repeat_fs"}, 32'(o_frame_start), 32'h1);
    end
  endtask

  initial begin
    for (int d = 0; d < D; d++) sh[d] = 4'd0;
    rst = 1'b1;
    bcd = 16'h1234;
    dp  = 4'b0100;
    #1 rst = 1'b0;
    #1 chk_zero("reset_async");
    for (int n = 0; n < 3; n++) step();
    chk_zero("reset_hold");
    release_and_check("reset");

    // decode
    wait_digit(0);
    chk("dec_d0_seg", 32'(o_seg), 32'b1100110);
    wait_digit(1);
    chk("dec_d1_seg", 32'(o_seg), 32'b1001111);
    wait_digit(2);
    chk("dec_d2_seg", 32'(o_seg), 32'b1011011);
    chk("dec_d2_dp",  32'(o_dp), 32'd1);
    wait_digit(3);
    chk("dec_d3_seg", 32'(o_seg), 32'b0000110);

    // frame coherence
    wait_digit(2);
    bcd = 16'h5678;
    wait_digit(3);
    chk("coh_old_d3", 32'(o_seg), 32'b0000110);
    wait_digit(0);
    chk("coh_new_d0", 32'(o_seg), 32'b1111111);
    wait_digit(1);
    chk("coh_new_d1", 32'(o_seg), 32'b0000111);
    wait_digit(2);
    chk("coh_new_d2", 32'(o_seg), 32'b1111101);
    wait_digit(3);
    chk("coh_new_d3", 32'(o_seg), 32'b1101101);

    // invalid BCD
    bcd = 16'h12C4;
    dp  = 4'b0010;
    wait_digit(0);
    wait_digit(1);
    chk("inv_d1_seg", 32'(o_seg), 32'b1000000);
    chk("inv_d1_dp",  32'(o_dp), 32'd1);

    // leading zeros
    bcd = 16'h0050;
    dp  = 4'b0000;
    wait_digit(0);
    chk("lzb_d0_seg", 32'(o_seg), 32'b0111111);
    wait_digit(1);
    chk("lzb_d1_seg", 32'(o_seg), 32'b1101101);
    wait_digit(2);
    chk("lzb_d2_sel", 32'(o_digit_sel), 32'b0100);
    wait_digit(3);
    chk("lzb_d3_sel", 32'(o_digit_sel), 32'b1000);
`ifdef SEG7_LZB_EN
    chk("lzb_d3_seg", 32'(o_seg), 32'd0);
`else
    chk("lzb_d3_seg", 32'(o_seg), 32'b0111111);
`endif
    dp = 4'b1000;
    wait_digit(2);
    chk("lzb_dp_d2_seg", 32'(o_seg), 32'b0111111);
    wait_digit(3);
    chk("lzb_dp_d3_seg", 32'(o_seg), 32'b0111111);
    chk("lzb_dp_d3_dp",  32'(o_dp), 32'd1);

    // mid-frame reset during digit 2
    bcd = 16'h1234;
    dp  = 4'b0100;
    wait_digit(2);
    step();
    #2 rst = 1'b0;
    #1 chk_zero("midrst_async");
    step();
    chk_zero("midrst_hold");
    release_and_check("midrst");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step();
      if ($urandom_range(0, 5) == 0) begin
        for (int d = 0; d < D; d++)
          bcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      end
      if ($urandom_range(0, 80) == 0) begin
        #2 rst = 1'b0;
        #1 chk_zero("rnd_rst_async");
        step();
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver. It takes a packed BCD word plus per-digit decimal points and decodes each nibble to segments. It scans the digits with a programmable dwell time and a blanking dead-time between digits to suppress ghosting. Input data is latched once per frame so a displayed frame is always coherent. It sits between the BCD counter/formatter logic and the board-level segment/anode pins.

## Interface
- DIGITS, 4, number of digits scanned (≥1)
- SCAN_DIV, 10, clock cycles each digit is driven (≥1)
- BLANK_CYCLES, 2, dead-time cycles between digits with all selects off (≥1)

- i_clk  input  1  system clock; one clock domain only
- i_rst  input  1  asynchronous, active-low reset
- i_bcd_data  input  DIGITS*4  packed nibbles; digit k = i_bcd_data[4k+3:4k], digit 0 least significant
- i_dp  input  DIGITS  decimal point per digit
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- o_dp  output  1  decimal point of the selected digit, active-high
- o_digit_sel  output  DIGITS  one-hot digit enable, active-high; all-zero during blanking
- o_frame_start  output  1  one-cycle pulse when a new frame is latched

## Operation
- FSM states: BLANK, SHOW. Registers: state, dwell counter cnt (width clog2(max(SCAN_DIV,BLANK_CYCLES))), digit index idx (width clog2(DIGITS), min 1), shadow data/dp, leading-zero mask.
- BLANK: o_digit_sel=0, o_seg=0, o_dp=0. When cnt==BLANK_CYCLES-1: cnt←0, state←SHOW, idx←(idx==DIGITS-1)?0:idx+1.
- SHOW: o_digit_sel=1<<idx, o_seg=decode(shadow nibble idx), o_dp=shadow dp[idx]. When cnt==SCAN_DIV-1: cnt←0, state←BLANK.
- Frame latch: on the edge that enters SHOW with idx becoming 0, i_bcd_data and i_dp are copied to shadow, and o_frame_start=1 for that cycle. Digit 0 displays the values sampled on that same edge. Input changes mid-frame take effect from the next frame only.
- Decode: 0–9 use standard glyphs (0=0111111, 1=0000110, …, 9=1101111). Nibbles 10–15 show a dash (1000000). dp is passed through unaffected.
- Scan order: idx 0,1,…,DIGITS-1, then wrap. Frame period = DIGITS*(SCAN_DIV+BLANK_CYCLES) cycles.
- DIGITS=1: idx stays 0, and every SHOW entry is a frame latch.

## Timing
- Reset (async assert, any time including mid-digit): all outputs 0 immediately. state=BLANK, cnt=0, idx=DIGITS-1, shadow=0.
- After reset release: BLANK_CYCLES cycles of blanking, then digit 0 SHOW with o_frame_start pulse.
- All outputs are registered. o_digit_sel, o_seg, o_dp and o_frame_start change on the same edge as state; there is no cycle of stale segments with a new select.
- Dwell is exactly SCAN_DIV cycles of SHOW and BLANK_CYCLES cycles of BLANK per digit, with no jitter.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - Working from digit DIGITS-1 downward, each digit whose shadow nibble is 0 and whose dp is 0 has o_seg=0. The run stops at the first digit failing either condition.
  - Digit 0 is never blanked.
  - o_digit_sel timing is unchanged.
  - The mask is computed at frame latch and registered.
- SEG7_LZB_EN undefined: every digit is decoded literally, and no mask logic is synthesised.

## Structure
- seg7_pkg: FSM state encoding, 7-bit glyph constants (digits 0–9, dash, blank), segment bit-order constants, clog2 function.
- One sub-module, seg7_decoder: combinational 4-bit → 7-bit glyph decoder, instantiated once on the selected shadow nibble.

## Test plan
Configuration for all tests: DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
- Reset: assert i_rst=0 → all outputs 0. After release, first edge → o_digit_sel=0001 with o_frame_start=1. Select held 4 cycles, then 0000 for 1 cycle, then 0010. Frame repeats every 20 cycles.
- Decode: i_bcd_data=16'h1234, i_dp=4'b0100 → digit0 o_seg=1100110, digit1 o_seg=1001111, digit2 o_seg=1011011 with o_dp=1, digit3 o_seg=0000110.
- Frame coherence: change i_bcd_data 16'h1234→16'h5678 while digit 2 is shown → digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
- Invalid BCD: nibble 0xC on digit 1 → o_seg=1000000; dp unaffected.
- LZB: i_bcd_data=16'h0050, i_dp=0.
  - With SEG7_LZB_EN: digits 3 and 2 show o_seg=0 while still selected; digit1=1101101, digit0=0111111.
  - Without SEG7_LZB_EN: digit3=0111111.
  - With SEG7_LZB_EN and i_dp=4'b1000: nothing is blanked.
- Mid-frame reset: pulse i_rst low for 1 cycle during digit 2 SHOW → outputs 0 asynchronously; the restart sequence is identical to the reset test.
